inst_fetcher: RTL and testbench
===============================

INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on the rising edge.
REQ-002 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have rdy, input, 1, global enable; when 0, all state holds.
REQ-004 SHALL have out_mem_req, output, 1, instruction-word read request to the memory controller.
REQ-005 SHALL have out_mem_addr, output, 32, word-aligned read address, held stable while out_mem_req=1.
REQ-006 SHALL have in_mem_valid, input, 1, one-cycle pulse meaning in_mem_inst is valid.
REQ-007 SHALL have in_mem_inst, input, 32, returned instruction word.
REQ-008 SHALL have out_dcd_valid, output, 1, out_dcd_inst/pc/jump_flag carry a real instruction this cycle.
REQ-009 SHALL have out_dcd_inst, output, 32, instruction to the decoder; 0 when not valid.
REQ-010 SHALL have out_dcd_pc, output, 32, PC of out_dcd_inst.
REQ-011 SHALL have out_dcd_jump_flag, output, 1, predicted-taken flag for out_dcd_inst.
REQ-012 SHALL have in_stall, input, 1, downstream structure (RS/LSB/ROB) full; no issue this cycle.
REQ-013 SHALL have in_rob_flush, input, 1, mispredict redirect.
REQ-014 SHALL have in_rob_target_pc, input, 32, redirect PC.
REQ-015 SHALL have in_rob_br_commit, input, 1, conditional-branch outcome update strobe.
REQ-016 SHALL have in_rob_br_pc, input, 32, PC of the committed branch.
REQ-017 SHALL have in_rob_br_taken, input, 1, actual outcome of the committed branch.
REQ-018 SHALL use the parameter ICACHE_ENTRIES, default 16, number of direct-mapped one-word I-cache lines.
REQ-019 SHALL use the parameter BHT_ENTRIES, default 16, number of 2-bit branch counters.

Function
REQ-020 SHALL use an I-cache with index pc[5:2], tag pc[31:6], one valid bit per line and one 32-bit word per line.
REQ-021 SHALL use a BHT indexed by pc[5:2] of saturating 2-bit counters; predict taken iff counter[1]=1.
REQ-022 SHALL have two FSM states, IDLE and MEM_WAIT.
REQ-023 IDLE, no flush/stall, hit: next edge out_dcd_valid=1, out_dcd_inst=line word, out_dcd_pc=pc, pc<=next_pc, giving a throughput of one instruction per cycle.
REQ-024 next_pc: JAL (opcode 1101111) -> pc+J-imm, jump_flag=1; BRANCH (1100011) with predict taken -> pc+B-imm, jump_flag=1; all other opcodes, including JALR -> pc+4, jump_flag=0; all adds are 32-bit with wrap-around.
REQ-025 IDLE miss: out_dcd_valid<=0, out_mem_addr<=pc, out_mem_req<=1, next state MEM_WAIT.
REQ-026 MEM_WAIT: out_mem_req and out_mem_addr SHALL be held; out_dcd_valid=0.
REQ-027 MEM_WAIT with in_mem_valid=1: write line[out_mem_addr index] with in_mem_inst, set its tag and valid bit, out_mem_req<=0, next state IDLE; the following cycle hits.
REQ-028 in_stall=1 in IDLE: out_dcd_valid<=0, pc held, cache and BHT unchanged; a miss request SHALL still be launched.
REQ-029 in_rob_flush=1 has the highest priority: pc<=in_rob_target_pc, out_dcd_valid<=0, no issue that cycle.
REQ-030 A flush in MEM_WAIT SHALL NOT cancel the outstanding request; the fill completes into the cache at out_mem_addr, then the FSM returns to IDLE.
REQ-031 A flush coinciding with in_mem_valid SHALL cause both the cache write and the pc redirect to take effect; the next state is IDLE.
REQ-032 in_rob_br_commit=1: counter[in_rob_br_pc[5:2]] +1 if taken, -1 if not, saturating at 3 and 0.
REQ-033 A same-cycle BHT update and lookup at the same index SHALL make the prediction use the pre-update value.
REQ-034 rdy=0: pc, FSM, cache, BHT and request outputs hold; out_dcd_valid<=0; in_mem_valid still SHALL be captured if in MEM_WAIT.

Reset
REQ-035 rst=1 SHALL set pc=0, state=IDLE, all cache valid bits=0, all BHT counters=01 (weakly not-taken).
REQ-036 rst=1 SHALL set out_mem_req=0, out_mem_addr=0, out_dcd_valid=0, out_dcd_inst=0, out_dcd_pc=0, out_dcd_jump_flag=0.
REQ-037 Reset SHALL override rdy, flush and any outstanding request; a late in_mem_valid in IDLE after reset SHALL be ignored.

Verification
REQ-038 Cold start: after reset, in_mem_inst=0x00000013 returned 3 cycles after req -> req addr 0, the fill is written, next cycle valid=1, pc=0, inst=0x13, jump_flag=0.
REQ-039 Hot loop: cached JAL x0,-4 at 0x4 -> valid every cycle; pcs alternate 0x0, 0x4, jump_flag=1 on 0x4 entries.
REQ-040 BHT: commit taken twice for branch at 0x8 -> counter 01->10->11; the next fetch of 0x8 gives jump_flag=1 and next pc=0x8+B-imm; three not-taken commits -> 00 with no underflow.
REQ-041 Stall: in_stall=1 for 4 cycles at a hit -> valid=0 and pc constant; release -> the same instruction issues once.
REQ-042 Flush during MEM_WAIT: flush to 0x100 while fetching 0x40 -> the fill still lands at index 0 with tag of 0x40; the next request is for 0x100 and no instruction from 0x40 is issued.
REQ-043 rdy=0 for 2 cycles mid-stream -> no valid output; resumes at the same pc without skipping or duplicating.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch unit: direct-mapped one-word I-cache, 2-bit BHT prediction for
// JAL/BRANCH, single outstanding miss to the memory controller.
module inst_fetcher #(
  parameter int ICACHE_ENTRIES = 16,
  parameter int BHT_ENTRIES    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_mem_req,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_valid,
  input  logic [31:0] in_mem_inst,
  output logic        out_dcd_valid,
  output logic [31:0] out_dcd_inst,
  output logic [31:0] out_dcd_pc,
  output logic        out_dcd_jump_flag,
  input  logic        in_stall,
  input  logic        in_rob_flush,
  input  logic [31:0] in_rob_target_pc,
  input  logic        in_rob_br_commit,
  input  logic [31:0] in_rob_br_pc,
  input  logic        in_rob_br_taken
);

  localparam int CIW  = $clog2(ICACHE_ENTRIES);
  localparam int BIW  = $clog2(BHT_ENTRIES);
  localparam int TAGW = 32 - CIW - 2;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] dpc_q, dpc_d;
  logic        jf_q, jf_d;

  logic [ICACHE_ENTRIES-1:0] line_vld_q;
  logic [TAGW-1:0]           line_tag_q  [ICACHE_ENTRIES];
  logic [31:0]               line_word_q [ICACHE_ENTRIES];
  logic [1:0]                bht_q       [BHT_ENTRIES];

  logic [CIW-1:0]     pc_idx, fill_idx;
  logic [BIW-1:0]     pc_bidx, br_bidx;
  logic               hit, fill, pred_taken, take_jump;
  logic [31:0]        word, next_pc;
  logic signed [31:0] j_imm, b_imm;
  logic               unused_bits;

  function automatic logic [1:0] bht_sat_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else       return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign pc_idx     = pc_q[CIW+1:2];
  assign fill_idx   = addr_q[CIW+1:2];
  assign pc_bidx    = pc_q[BIW+1:2];
  assign br_bidx    = in_rob_br_pc[BIW+1:2];
  assign word       = line_word_q[pc_idx];
  assign hit        = line_vld_q[pc_idx] && (line_tag_q[pc_idx] == pc_q[31:CIW+2]);
  assign fill       = (state_q == MEM_WAIT) && in_mem_valid;
  // The BHT read sees the registered counter, so a same-cycle commit only affects later fetches.
  assign pred_taken = bht_q[pc_bidx][1];
  assign unused_bits = ^{in_rob_br_pc[31:BIW+2], in_rob_br_pc[1:0], addr_q[1:0]};

  always_comb begin
    j_imm     = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    b_imm     = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
    take_jump = 1'b0;
    next_pc   = pc_q + 32'd4;
    if (word[6:0] == OP_JAL) begin
      take_jump = 1'b1;
      next_pc   = pc_q + $unsigned(j_imm);
    end else if (word[6:0] == OP_BRANCH && pred_taken) begin
      take_jump = 1'b1;
      next_pc   = pc_q + $unsigned(b_imm);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A returning fill always completes, even under flush or rdy=0.
  always_comb begin
    state_d = state_q;
    if (fill)
      state_d = IDLE;
    else if (rdy && !in_rob_flush && state_q == IDLE && !hit)
      state_d = MEM_WAIT;
  end

  always_comb begin
    pc_d   = pc_q;
    req_d  = req_q;
    addr_d = addr_q;
    vld_d  = 1'b0;
    inst_d = 32'd0;
    dpc_d  = 32'd0;
    jf_d   = 1'b0;
    if (fill) req_d = 1'b0;
    if (rdy) begin
      if (in_rob_flush) begin
        pc_d = in_rob_target_pc;
      end else if (state_q == IDLE) begin
        if (!hit) begin
          req_d  = 1'b1;
          addr_d = {pc_q[31:2], 2'b00};
        end else if (!in_stall) begin
          vld_d  = 1'b1;
          inst_d = word;
          dpc_d  = pc_q;
          jf_d   = take_jump;
          pc_d   = next_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= 32'd0;
      req_q  <= 1'b0;
      addr_q <= 32'd0;
      vld_q  <= 1'b0;
      inst_q <= 32'd0;
      dpc_q  <= 32'd0;
      jf_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      inst_q <= inst_d;
      dpc_q  <= dpc_d;
      jf_q   <= jf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       line_vld_q <= '0;
    else if (fill) line_vld_q[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag_q[fill_idx]  <= addr_q[31:CIW+2];
      line_word_q[fill_idx] <= in_mem_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (rdy && in_rob_br_commit) begin
      bht_q[br_bidx] <= bht_sat_step(bht_q[br_bidx], in_rob_br_taken);
    end
  end

  assign out_mem_req       = req_q;
  assign out_mem_addr      = addr_q;
  assign out_dcd_valid     = vld_q;
  assign out_dcd_inst      = inst_q;
  assign out_dcd_pc        = dpc_q;
  assign out_dcd_jump_flag = jf_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed vector table, multi-cycle corner sequences, and a
// randomized run checked against an architectural next-pc model.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, in_stall, in_rob_flush, in_rob_br_commit, in_rob_br_taken;
  logic [31:0] in_rob_target_pc, in_rob_br_pc;
  logic        out_mem_req, out_dcd_valid, out_dcd_jump_flag;
  logic [31:0] out_mem_addr, out_dcd_inst, out_dcd_pc;
  logic        in_mem_valid;
  logic [31:0] in_mem_inst;

  logic        auto_en, mv_man, mv_auto;
  logic [31:0] mi_man, mi_auto;
  assign in_mem_valid = auto_en ? mv_auto : mv_man;
  assign in_mem_inst  = auto_en ? mi_auto : mi_man;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] prog [64];
  int          prog_kind [64];
  int          prog_off [64];
  int          bht_m [16];

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] JM4  = 32'hFFDFF06F;
  localparam logic [31:0] I40  = 32'h00100093;
  localparam logic [31:0] I100 = 32'h00200093;
  localparam logic [31:0] I104 = 32'h00300093;
  localparam logic [31:0] I44  = 32'h00400093;

  inst_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
    .in_mem_valid(in_mem_valid), .in_mem_inst(in_mem_inst),
    .out_dcd_valid(out_dcd_valid), .out_dcd_inst(out_dcd_inst),
    .out_dcd_pc(out_dcd_pc), .out_dcd_jump_flag(out_dcd_jump_flag),
    .in_stall(in_stall), .in_rob_flush(in_rob_flush), .in_rob_target_pc(in_rob_target_pc),
    .in_rob_br_commit(in_rob_br_commit), .in_rob_br_pc(in_rob_br_pc),
    .in_rob_br_taken(in_rob_br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, stall, flush;
    logic [31:0] tgt;
    logic        mv;
    logic [31:0] mi;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_inst;
    logic        e_jf;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic r, input logic y, input logic s, input logic f,
                              input logic [31:0] t, input logic v, input logic [31:0] mi,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei, input logic ej);
    vec_t x;
    x.rst = r; x.rdy = y; x.stall = s; x.flush = f; x.tgt = t; x.mv = v; x.mi = mi;
    x.e_req = er; x.e_addr = ea; x.e_vld = ev; x.e_pc = ep; x.e_inst = ei; x.e_jf = ej;
    return x;
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd0, 5'd0, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic f, input logic [31:0] t, input logic v, input logic [31:0] i);
    in_rob_flush = f; in_rob_target_pc = t; mv_man = v; mi_man = i;
    step();
    in_rob_flush = 1'b0; mv_man = 1'b0;
  endtask

  task automatic commit(input logic [31:0] p, input logic t);
    in_rob_br_commit = 1'b1; in_rob_br_pc = p; in_rob_br_taken = t;
    step();
    in_rob_br_commit = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (out_dcd_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fetch_check(input logic [31:0] a, input logic ejf, input logic [31:0] enext,
                             input string name);
    logic ok;
    cyc(1'b1, a, 1'b0, 32'd0);
    wait_valid(ok);
    chk({name, "_arrive"}, ok, 1);
    if (ok) begin
      chk({name, "_pc"}, out_dcd_pc, a);
      chk({name, "_jf"}, out_dcd_jump_flag, ejf);
    end
    wait_valid(ok);
    chk({name, "_next_arrive"}, ok, 1);
    if (ok) chk({name, "_next_pc"}, out_dcd_pc, enext);
  endtask

  // Memory controller model: answers each request after 1..4 cycles from prog[].
  initial begin
    logic        busy;
    int          lat;
    logic [31:0] raddr;
    busy = 1'b0; lat = 0; raddr = 32'd0; mv_auto = 1'b0; mi_auto = 32'd0;
    forever begin
      @(negedge clk);
      if (!auto_en) begin
        busy = 1'b0; mv_auto = 1'b0;
      end else if (mv_auto) begin
        mv_auto = 1'b0;
      end else if (out_mem_req) begin
        if (!busy) begin
          busy = 1'b1; lat = $urandom_range(0, 3); raddr = out_mem_addr;
        end else begin
          chk("mem_addr_hold", out_mem_addr, raddr);
        end
        if (lat == 0) begin
          mv_auto = 1'b1; mi_auto = prog[raddr[7:2]]; busy = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        r_rdy, r_stall, r_flush, r_commit, r_taken, ejf;
    logic [31:0] r_tgt, r_cpc, exp_pc, w;
    int          n_issue, r, off, k;

    rst = 1'b1; rdy = 1'b1; in_stall = 1'b0; in_rob_flush = 1'b0; in_rob_target_pc = 32'd0;
    in_rob_br_commit = 1'b0; in_rob_br_pc = 32'd0; in_rob_br_taken = 1'b0;
    auto_en = 1'b0; mv_man = 1'b0; mi_man = 32'd0;

    //            rst rdy stl fl tgt    mv mi    req addr vld pc  inst jf
    tbl[0]  = mk(1, 1, 0, 0, 0,     0, 0,    0, 0, 0, 0, 0,    0);
    tbl[1]  = mk(1, 0, 0, 1, 32'h80, 1, NOP, 0, 0, 0, 0, 0,    0);
    tbl[2]  = mk(0, 1, 0, 0, 0,     0, 0,    1, 0, 0, 0, 0,    0);
    tbl[3]  = mk(0, 1, 0, 0, 0,     0, 0,    1, 0, 0, 0, 0,    0);
    tbl[4]  = mk(0, 1, 0, 0, 0,     0, 0,    1, 0, 0, 0, 0,    0);
    tbl[5]  = mk(0, 1, 0, 0, 0,     1, NOP,  0, 0, 0, 0, 0,    0);
    tbl[6]  = mk(0, 1, 0, 0, 0,     0, 0,    0, 0, 1, 0, NOP,  0);
    tbl[7]  = mk(0, 1, 0, 0, 0,     0, 0,    1, 4, 0, 0, 0,    0);
    tbl[8]  = mk(0, 1, 0, 0, 0,     1, JM4,  0, 4, 0, 0, 0,    0);
    tbl[9]  = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 4, JM4,  1);
    tbl[10] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 0, NOP,  0);
    tbl[11] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 4, JM4,  1);
    tbl[12] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 0, NOP,  0);
    tbl[13] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 4, JM4,  1);
    tbl[14] = mk(0, 1, 1, 0, 0,     0, 0,    0, 4, 0, 0, 0,    0);
    tbl[15] = mk(0, 1, 1, 0, 0,     0, 0,    0, 4, 0, 0, 0,    0);
    tbl[16] = mk(0, 1, 1, 0, 0,     0, 0,    0, 4, 0, 0, 0,    0);
    tbl[17] = mk(0, 1, 1, 0, 0,     0, 0,    0, 4, 0, 0, 0,    0);
    tbl[18] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 0, NOP,  0);
    tbl[19] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 4, JM4,  1);
    tbl[20] = mk(0, 0, 0, 0, 0,     0, 0,    0, 4, 0, 0, 0,    0);
    tbl[21] = mk(0, 0, 0, 0, 0,     0, 0,    0, 4, 0, 0, 0,    0);
    tbl[22] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 0, NOP,  0);
    tbl[23] = mk(0, 1, 0, 0, 0,     0, 0,    0, 4, 1, 4, JM4,  1);

    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].rst; rdy = tbl[i].rdy; in_stall = tbl[i].stall;
      in_rob_flush = tbl[i].flush; in_rob_target_pc = tbl[i].tgt;
      mv_man = tbl[i].mv; mi_man = tbl[i].mi;
      step();
      chk($sformatf("t%0d_req", i), out_mem_req, tbl[i].e_req);
      chk($sformatf("t%0d_addr", i), out_mem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), out_dcd_valid, tbl[i].e_vld);
      chk($sformatf("t%0d_inst", i), out_dcd_inst, tbl[i].e_inst);
      if (tbl[i].e_vld) begin
        chk($sformatf("t%0d_pc", i), out_dcd_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_jf", i), out_dcd_jump_flag, tbl[i].e_jf);
      end
    end
    rst = 1'b0; rdy = 1'b1; in_stall = 1'b0; in_rob_flush = 1'b0; mv_man = 1'b0;

    // Flush while a miss is outstanding
    cyc(1, 32'h40, 0, 0);   chk("fl1_req", out_mem_req, 0); chk("fl1_vld", out_dcd_valid, 0);
    cyc(0, 0, 0, 0);        chk("fl2_req", out_mem_req, 1); chk("fl2_addr", out_mem_addr, 32'h40);
    cyc(1, 32'h100, 0, 0);  chk("fl3_req", out_mem_req, 1); chk("fl3_addr", out_mem_addr, 32'h40);
    chk("fl3_vld", out_dcd_valid, 0);
    cyc(0, 0, 1, I40);      chk("fl4_req", out_mem_req, 0); chk("fl4_vld", out_dcd_valid, 0);
    cyc(0, 0, 0, 0);        chk("fl5_req", out_mem_req, 1); chk("fl5_addr", out_mem_addr, 32'h100);
    chk("fl5_vld", out_dcd_valid, 0);
    cyc(0, 0, 1, I100);     chk("fl6_req", out_mem_req, 0);
    cyc(0, 0, 0, 0);        chk("fl7_vld", out_dcd_valid, 1); chk("fl7_pc", out_dcd_pc, 32'h100);
    chk("fl7_inst", out_dcd_inst, I100);
    cyc(0, 0, 0, 0);        chk("fl8_req", out_mem_req, 1); chk("fl8_addr", out_mem_addr, 32'h104);
    cyc(0, 0, 1, I104);     chk("fl9_req", out_mem_req, 0);
    cyc(1, 32'h40, 0, 0);   chk("fl10_vld", out_dcd_valid, 0);
    cyc(0, 0, 0, 0);        chk("fl11_req", out_mem_req, 1); chk("fl11_addr", out_mem_addr, 32'h40);
    cyc(1, 32'h104, 0, 0);  chk("fl12_req", out_mem_req, 1); chk("fl12_addr", out_mem_addr, 32'h40);
    cyc(0, 0, 1, I40);      chk("fl13_req", out_mem_req, 0); chk("fl13_vld", out_dcd_valid, 0);
    cyc(0, 0, 0, 0);        chk("fl14_vld", out_dcd_valid, 1); chk("fl14_pc", out_dcd_pc, 32'h104);
    chk("fl14_inst", out_dcd_inst, I104);
    cyc(1, 32'h40, 0, 0);   chk("fl15_req", out_mem_req, 0); chk("fl15_vld", out_dcd_valid, 0);
    cyc(0, 0, 0, 0);        chk("fl16_vld", out_dcd_valid, 1); chk("fl16_pc", out_dcd_pc, 32'h40);
    chk("fl16_inst", out_dcd_inst, I40); chk("fl16_req", out_mem_req, 0);

    // Flush on the same edge as the fill
    cyc(0, 0, 0, 0);        chk("ff1_req", out_mem_req, 1); chk("ff1_addr", out_mem_addr, 32'h44);
    cyc(1, 32'h40, 1, I44); chk("ff2_req", out_mem_req, 0); chk("ff2_vld", out_dcd_valid, 0);
    cyc(0, 0, 0, 0);        chk("ff3_vld", out_dcd_valid, 1); chk("ff3_pc", out_dcd_pc, 32'h40);
    chk("ff3_inst", out_dcd_inst, I40);
    cyc(0, 0, 0, 0);        chk("ff4_vld", out_dcd_valid, 1); chk("ff4_pc", out_dcd_pc, 32'h44);
    chk("ff4_inst", out_dcd_inst, I44);
    cyc(0, 0, 0, 0);        chk("ff5_req", out_mem_req, 1); chk("ff5_addr", out_mem_addr, 32'h48);

    // Reset over an outstanding request, then a stray fill pulse in IDLE
    rst = 1'b1; rdy = 1'b0;
    step();
    chk("rs1_req", out_mem_req, 0); chk("rs1_addr", out_mem_addr, 0); chk("rs1_vld", out_dcd_valid, 0);
    rst = 1'b0;
    cyc(0, 0, 1, NOP);      chk("rs2_req", out_mem_req, 0); chk("rs2_vld", out_dcd_valid, 0);
    rdy = 1'b1;
    cyc(0, 0, 0, 0);        chk("rs3_req", out_mem_req, 1); chk("rs3_addr", out_mem_addr, 0);
    chk("rs3_vld", out_dcd_valid, 0);

    // BHT training on a branch at 0x8 with offset +16
    for (int i = 0; i < 64; i++) begin
      prog[i] = NOP; prog_kind[i] = 0; prog_off[i] = 4;
    end
    prog[2] = enc_b(16); prog_kind[2] = 2; prog_off[2] = 16;
    rst = 1'b1; step(); step(); rst = 1'b0; auto_en = 1'b1;
    repeat (3) commit(32'h8, 1'b1);
    fetch_check(32'h8, 1'b1, 32'h18, "bht_sat3");
    repeat (2) commit(32'h8, 1'b0);
    fetch_check(32'h8, 1'b0, 32'hC, "bht_dec");
    repeat (2) commit(32'h8, 1'b0);
    repeat (2) commit(32'h8, 1'b1);
    fetch_check(32'h8, 1'b1, 32'h18, "bht_sat0");

    // Randomized run against the architectural model
    auto_en = 1'b0; rst = 1'b1; step(); step(); rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r < 2) begin
        off = (int'($urandom_range(0, 32)) - 16) * 4;
        prog[i] = enc_j(off); prog_kind[i] = 1; prog_off[i] = off;
      end else if (r < 5) begin
        off = int'($urandom_range(1, 16)) * 4;
        if (w[0]) off = -off;
        prog[i] = enc_b(off); prog_kind[i] = 2; prog_off[i] = off;
      end else if (r == 5) begin
        prog[i] = {w[31:15], 3'b000, w[11:7], 7'b1100111}; prog_kind[i] = 0; prog_off[i] = 4;
      end else begin
        prog[i] = {w[31:7], 7'b0010011}; prog_kind[i] = 0; prog_off[i] = 4;
      end
    end
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    exp_pc = 32'd0; n_issue = 0; auto_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      r_rdy    = ($urandom_range(0, 9) != 0);
      r_stall  = ($urandom_range(0, 4) == 0);
      r_flush  = r_rdy && ($urandom_range(0, 39) == 0);
      r_tgt    = 32'($urandom_range(0, 63)) * 4;
      r_commit = ($urandom_range(0, 3) == 0);
      r_cpc    = 32'($urandom_range(0, 15)) * 4;
      r_taken  = $urandom_range(0, 1) != 0;
      rdy = r_rdy; in_stall = r_stall; in_rob_flush = r_flush; in_rob_target_pc = r_tgt;
      in_rob_br_commit = r_commit; in_rob_br_pc = r_cpc; in_rob_br_taken = r_taken;
      step();
      if (out_dcd_valid) begin
        k   = prog_kind[exp_pc[7:2]];
        ejf = (k == 1) || (k == 2 && bht_m[exp_pc[5:2]] >= 2);
        chk("rnd_pc", out_dcd_pc, exp_pc);
        chk("rnd_inst", out_dcd_inst, prog[exp_pc[7:2]]);
        chk("rnd_jf", out_dcd_jump_flag, ejf);
        exp_pc = exp_pc + 32'(ejf ? prog_off[exp_pc[7:2]] : 4);
        n_issue++;
      end else begin
        chk("rnd_idle_inst", out_dcd_inst, 0);
      end
      if (!r_rdy || r_flush || r_stall) chk("rnd_no_issue", out_dcd_valid, 0);
      if (r_rdy && r_commit) begin
        if (r_taken) bht_m[r_cpc[5:2]] = (bht_m[r_cpc[5:2]] == 3) ? 3 : bht_m[r_cpc[5:2]] + 1;
        else         bht_m[r_cpc[5:2]] = (bht_m[r_cpc[5:2]] == 0) ? 0 : bht_m[r_cpc[5:2]] - 1;
      end
      if (r_flush) exp_pc = r_tgt;
      if (n_fail > 50) break;
    end
    in_rob_br_commit = 1'b0; in_rob_flush = 1'b0; in_stall = 1'b0; rdy = 1'b1;
    chk("rnd_progress", (n_issue >= 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
